wbits_multi: RTL
================

WBITS_MULTI -- requirements
Module: wbits_multi

Interface
REQ-001 Parameter DATA_W, default 32, memory word width in bits (power of 2, >=8).
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter MAX_BITS, default 64, maximum bit-field length per operation.
REQ-004 clk_i  in  1  clock; all state on rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 start_i  in  1  operation request; sampled only in IDLE.
REQ-007 addr_i  in  ADDR_W  word-aligned base byte address; low log2(DATA_W/8) bits ignored.
REQ-008 off_i  in  log2(DATA_W)  bit offset of field within first word.
REQ-009 nbits_i  in  log2(MAX_BITS)+1  field length in bits.
REQ-010 src_i  in  MAX_BITS  field value; bit 0 is the LSB of the field.
REQ-011 mem_req_o  out  1  write request valid.
REQ-012 mem_gnt_i  in  1  request accepted.
REQ-013 mem_addr_o  out  ADDR_W  word byte address.
REQ-014 mem_wdata_o  out  DATA_W  write data.
REQ-015 mem_wmask_o  out  DATA_W  per-bit write mask; 1 = write bit.
REQ-016 mem_rvalid_i  in  1  write response.
REQ-017 mem_err_i  in  1  response error; qualified by mem_rvalid_i.
REQ-018 mem_needed_o  out  1  one-cycle pulse: operation will access memory.
REQ-019 busy_o  out  1  high in any state other than IDLE.
REQ-020 done_o  out  1  one-cycle completion pulse.
REQ-021 error_o  out  1  last operation failed; level output.

Function
REQ-022 States: IDLE, REQ, WAIT, DONE.
REQ-023 In IDLE, start_i=1 latches addr_i, off_i, nbits_i, src_i, and clears error_o.
REQ-024 On the same accept edge, WORDS = ceil((off+nbits)/DATA_W) and word index k is set to 0.
REQ-025 On accept with 0<nbits_i<=MAX_BITS: next state REQ; mem_needed_o=1 for exactly the following cycle.
REQ-026 On accept with nbits_i=0: next state DONE; no memory request; mem_needed_o stays 0.
REQ-027 On accept with nbits_i>MAX_BITS: next state DONE with error_o=1; no memory request.
REQ-028 start_i outside IDLE is ignored.
REQ-029 In REQ, mem_req_o=1.
REQ-030 In REQ: mem_addr_o = base + k*(DATA_W/8), modulo 2^ADDR_W (wrap silently).
REQ-031 In REQ: mem_wdata_o = bits [k*DATA_W +: DATA_W] of (src << off).
REQ-032 In REQ: mem_wmask_o = the same slice of (((1<<nbits)-1) << off).
REQ-033 Bits of src_i above nbits SHALL NOT appear in mem_wdata_o (masked to zero).
REQ-034 mem_addr_o, mem_wdata_o and mem_wmask_o SHALL stay stable while mem_req_o=1 and mem_gnt_i=0.
REQ-035 REQ->WAIT on mem_gnt_i=1; mem_req_o deasserts the next cycle; at most one write outstanding.
REQ-036 In WAIT, mem_rvalid_i is accepted no earlier than the cycle after the grant.
REQ-037 WAIT, rvalid=1, err=0, k<WORDS-1: k increments, next state REQ.
REQ-038 WAIT, rvalid=1, err=0, k=WORDS-1: next state DONE.
REQ-039 WAIT, rvalid=1, err=1: remaining words abandoned, error_o=1, next state DONE.
REQ-040 mem_rvalid_i outside WAIT is ignored.
REQ-041 DONE lasts one cycle with done_o=1, then IDLE; first possible next accept is the cycle after DONE.
REQ-042 error_o holds its value until the next accepted start_i.
REQ-043 Minimum latency per word: 1 cycle REQ + 1 cycle WAIT; start accept to done_o >= 2*WORDS+1 cycles.

Reset
REQ-044 While rst_ni=0, immediately and asynchronously: state=IDLE, mem_req_o=0, mem_needed_o=0, busy_o=0, done_o=0, error_o=0, k=0.
REQ-045 Reset mid-operation aborts it; no further requests; responses arriving after reset are ignored.

Verification (DATA_W=32, MAX_BITS=64, gnt same cycle as req, rvalid one cycle later unless stated)
REQ-046 addr=0x100, off=4, nbits=8, src=0xAB: one write, addr 0x100, wdata 0x00000AB0, wmask 0x00000FF0; done_o=1, error_o=0.
REQ-047 off=28, nbits=8, src=0xCD: writes 0x100/0xD0000000/0xF0000000, then 0x104/0x0000000C/0x0000000F.
REQ-048 nbits=0: no mem_req_o, no mem_needed_o, done_o pulse the cycle after accept; nbits=65: same timing with error_o=1.
REQ-049 mem_gnt_i held low 3 cycles: mem_req_o/addr/wdata/wmask constant for 4 cycles; exactly one write issued.
REQ-050 off=0, nbits=64, src=0xFFFF_FFFF_0000_0001; first response has mem_err_i=1: second write never issued; done_o=1, error_o=1; error_o still 1 after DONE until next start.
REQ-051 rst_ni low during WAIT: all outputs 0 asynchronously; a late mem_rvalid_i after release causes no done_o and no further request.
REQ-052 addr=0xFFFF_FFFC, off=16, nbits=32: second write addr wraps to 0x0000_0000.

Source files
------------

// File: rtl/wbits_multi_if.sv
// wbits_multi_if: masked word-write memory port with one outstanding write.
interface wbits_multi_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_wmask;
  logic              mem_rvalid;
  logic              mem_err;
  modport master (output mem_req, mem_addr, mem_wdata, mem_wmask, input mem_gnt, mem_rvalid, mem_err);
  modport slave (input mem_req, mem_addr, mem_wdata, mem_wmask, output mem_gnt, mem_rvalid, mem_err);
endinterface

// File: rtl/wbits_multi.sv
// wbits_multi: writes a bit field of up to MAX_BITS at any bit offset as a run of masked word writes.
module wbits_multi #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MAX_BITS = 64,
  localparam int OFF_W = $clog2(DATA_W),
  localparam int NB_W = $clog2(MAX_BITS) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [OFF_W-1:0]    off_i,
  input  logic [NB_W-1:0]     nbits_i,
  input  logic [MAX_BITS-1:0] src_i,
  output logic                mem_needed_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  wbits_multi_if.master       mem
);
  localparam int NW = (MAX_BITS + DATA_W - 1) / DATA_W + 1;
  localparam int WIDE = NW * DATA_W;
  localparam int K_W = $clog2(NW + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  state_e state_q, state_d;
  logic [K_W-1:0] k_q, k_d, words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDE-1:0] data_q, data_d, mask_q, mask_d, field_m;
  logic err_q, err_d, needed_q, needed_d, too_long, skip;
  assign field_m = (WIDE'(1) << nbits_i) - WIDE'(1);
  assign too_long = int'(nbits_i) > MAX_BITS;
  assign skip = nbits_i == '0 || too_long;
  // data/mask are kept pre-shifted; each completed word shifts the next one into the low slice
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    words_d = words_q;
    addr_d = addr_q;
    data_d = data_q;
    mask_d = mask_q;
    err_d = err_q;
    needed_d = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = skip ? DONE : REQ;
        needed_d = !skip;
        err_d = too_long;
        k_d = '0;
        words_d = K_W'((int'(off_i) + int'(nbits_i) + DATA_W - 1) / DATA_W);
        addr_d = addr_i & ~ADDR_W'(DATA_W / 8 - 1);
        data_d = (WIDE'(src_i) & field_m) << off_i;
        mask_d = field_m << off_i;
      end
      REQ: state_d = mem.mem_gnt ? WAIT : REQ;
      WAIT: if (mem.mem_rvalid) begin
        if (mem.mem_err || k_q == words_q - K_W'(1)) begin
          state_d = DONE;
          err_d = mem.mem_err;
        end else begin
          state_d = REQ;
          k_d = k_q + K_W'(1);
          addr_d = addr_q + ADDR_W'(DATA_W / 8);
          data_d = data_q >> DATA_W;
          mask_d = mask_q >> DATA_W;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q <= '0;
      words_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      err_q <= 1'b0;
      needed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      words_q <= words_d;
      addr_q <= addr_d;
      data_q <= data_d;
      mask_q <= mask_d;
      err_q <= err_d;
      needed_q <= needed_d;
    end
  end
  assign mem.mem_req = state_q == REQ;
  assign mem.mem_addr = addr_q;
  assign mem.mem_wdata = data_q[DATA_W-1:0];
  assign mem.mem_wmask = mask_q[DATA_W-1:0];
  assign mem_needed_o = needed_q;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign error_o = err_q;
endmodule
